// File: rtl/instbuffer_ctrl_pkg.sv
// Shared constants and types for the instruction-buffer controller.
// The depth/pointer constants must agree with the instruction buffer itself.
package instbuffer_ctrl_pkg;

    localparam int INSTBUF_DEPTH        = 32;
    localparam int INSTBUF_PTR_W        = 5;
    localparam int INSTBUF_STALL_MARGIN = 2;

    // Controller sequencing: one settle cycle after reset, normal running,
    // and a recovery cycle after every flush.
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    typedef logic [31:0] perf_cnt_t;

endpackage

// File: rtl/instbuffer_ctrl_if.sv
// Handshake bundle between the instruction-buffer controller and its
// surroundings (BPU, decode, buffer). The controller uses the slave modport.
interface instbuffer_ctrl_if #(
    parameter int PTR_W = 5
) ();

    logic             flush_i;
    logic             inst1_valid_i;
    logic             inst2_valid_i;
    logic             id_ready_1_i;
    logic             id_ready_2_i;
    logic             fetch_inst_1_en_o;
    logic             fetch_inst_2_en_o;
    logic             send_inst_1_en_o;
    logic             send_inst_2_en_o;
    logic             buffer_flush_o;
    logic             bpu_stall_o;
    logic [PTR_W:0]   count_o;
    logic             empty_o;
    logic             full_o;
    logic [31:0]      stall_cycles_o;
    logic [31:0]      empty_cycles_o;

    modport slave (
        input  flush_i, inst1_valid_i, inst2_valid_i, id_ready_1_i, id_ready_2_i,
        output fetch_inst_1_en_o, fetch_inst_2_en_o, send_inst_1_en_o,
               send_inst_2_en_o, buffer_flush_o, bpu_stall_o, count_o,
               empty_o, full_o, stall_cycles_o, empty_cycles_o
    );

    modport master (
        output flush_i, inst1_valid_i, inst2_valid_i, id_ready_1_i, id_ready_2_i,
        input  fetch_inst_1_en_o, fetch_inst_2_en_o, send_inst_1_en_o,
               send_inst_2_en_o, buffer_flush_o, bpu_stall_o, count_o,
               empty_o, full_o, stall_cycles_o, empty_cycles_o
    );

endinterface

// File: rtl/instbuffer_ctrl_perf_cnt.sv
// Two saturating 32-bit event counters (BPU stall cycles, buffer-empty
// cycles). Only instantiated when INSTBUF_PERF_CNT_EN is defined.
module instbuffer_perf_cnt
    import instbuffer_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      stall_inc_i,
    input  logic      empty_inc_i,
    output perf_cnt_t stall_cycles_o,
    output perf_cnt_t empty_cycles_o
);

    perf_cnt_t stall_cnt_q, stall_cnt_d;
    perf_cnt_t empty_cnt_q, empty_cnt_d;

    // Next counter values: count the event, but hold at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        empty_cnt_d = empty_cnt_q;
        if (stall_inc_i && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
        if (empty_inc_i && (empty_cnt_q != '1)) empty_cnt_d = empty_cnt_q + 32'd1;
    end

    // Counter registers; only reset clears them, flush leaves them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            empty_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            empty_cnt_q <= empty_cnt_d;
        end
    end

    assign stall_cycles_o = stall_cnt_q;
    assign empty_cycles_o = empty_cnt_q;

endmodule

// File: rtl/instbuffer_ctrl.sv
// Occupancy / flow-control controller for the dual-issue instruction FIFO.
// Decides each cycle how many BPU slots to push and how many entries to pop
// toward decode, back-pressures the BPU and sequences flush recovery.
// Optional performance counters are built when INSTBUF_PERF_CNT_EN is defined.
module instbuffer_ctrl
    import instbuffer_ctrl_pkg::*;
#(
    parameter int DEPTH        = INSTBUF_DEPTH,
    parameter int PTR_W        = INSTBUF_PTR_W,
    parameter int STALL_MARGIN = INSTBUF_STALL_MARGIN
) (
    input  logic            clk,
    input  logic            rst_n,
    instbuffer_ctrl_if.slave bus
);

    localparam int CNT_W = PTR_W + 1;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t DEPTH_C  = cnt_t'(DEPTH);
    localparam cnt_t MARGIN_C = cnt_t'(STALL_MARGIN);

    state_e state_q, state_d;
    cnt_t   count_q, count_d;
    logic   empty_q, empty_d;
    logic   full_q,  full_d;

    cnt_t       free_slots;
    logic       run_en;
    logic       fetch1, fetch2, send1, send2, stall;
    logic [1:0] nfetch, nsend;

    // Per-cycle enables from registered occupancy; writes made this cycle
    // are not visible to the send decision.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        fetch1     = 1'b0;
        fetch2     = 1'b0;
        free_slots = DEPTH_C - count_q;
        run_en     = (state_q == RUN) && !bus.flush_i;

        if (run_en) begin
            unique case ({bus.inst1_valid_i, bus.inst2_valid_i})
                2'b11: begin
                    fetch1 = (free_slots >= cnt_t'(1));
                    fetch2 = (free_slots >= cnt_t'(2));
                end
                2'b10:   fetch1 = (free_slots >= cnt_t'(1));
                2'b01:   fetch2 = (free_slots >= cnt_t'(1));
                default: ;
            endcase
        end

        send1 = run_en && (count_q >= cnt_t'(1)) && bus.id_ready_1_i;
        send2 = run_en && (count_q >= cnt_t'(2)) && bus.id_ready_1_i && bus.id_ready_2_i;

        stall = (state_q != RUN) || (free_slots < MARGIN_C) ||
                (bus.inst1_valid_i && !fetch1) || (bus.inst2_valid_i && !fetch2);

        nfetch = {1'b0, fetch1} + {1'b0, fetch2};
        nsend  = {1'b0, send1}  + {1'b0, send2};
    end

    // Next state, occupancy and registered status flags.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (bus.flush_i) state_d = FLUSH;
            FLUSH:   state_d = bus.flush_i ? FLUSH : RUN;
            default: state_d = BOOT;
        endcase

        if (bus.flush_i) count_d = '0;
        else             count_d = count_q + cnt_t'(nfetch) - cnt_t'(nsend);

        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_C);
    end

    // FSM and occupancy registers; reset returns to BOOT with an empty buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            count_q <= count_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

    assign bus.fetch_inst_1_en_o = fetch1;
    assign bus.fetch_inst_2_en_o = fetch2;
    assign bus.send_inst_1_en_o  = send1;
    assign bus.send_inst_2_en_o  = send2;
    assign bus.buffer_flush_o    = bus.flush_i;
    assign bus.bpu_stall_o       = stall;
    assign bus.count_o           = count_q;
    assign bus.empty_o           = empty_q;
    assign bus.full_o            = full_q;

`ifdef INSTBUF_PERF_CNT_EN
    logic stall_inc, empty_inc;
    assign stall_inc = (state_q == RUN) && stall;
    assign empty_inc = (state_q == RUN) && empty_q;

    instbuffer_perf_cnt u_perf_cnt (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_inc_i    (stall_inc),
        .empty_inc_i    (empty_inc),
        .stall_cycles_o (bus.stall_cycles_o),
        .empty_cycles_o (bus.empty_cycles_o)
    );
`else
    assign bus.stall_cycles_o = '0;
    assign bus.empty_cycles_o = '0;
`endif

endmodule
